// File: rtl/ring_port_arbiter.sv
// Ring node switch stage: three input FIFOs (CW, CCW, local) feeding three
// registered outputs, each output arbitrated round-robin among the FIFO heads routed to it.
module ring_port_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [2:0]              in_valid,
    output logic [2:0]              in_ready,
    input  logic [3*DATA_WIDTH-1:0] in_data,
    input  logic [5:0]              in_route,
    output logic [2:0]              out_valid,
    input  logic [2:0]              out_ready,
    output logic [3*DATA_WIDTH-1:0] out_data,
    output logic [5:0]              out_src,
    output logic [CNT_WIDTH-1:0]    drop_count
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int ENT_W = DATA_WIDTH + 2;

    logic [ENT_W-1:0]      mem_q [3][FIFO_DEPTH];
    logic [ENT_W-1:0]      mem_d [3][FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q [3], wr_ptr_d [3];
    logic [PTR_W-1:0]      rd_ptr_q [3], rd_ptr_d [3];
    logic [CNT_W-1:0]      count_q [3], count_d [3];
    logic [1:0]            rr_ptr_q [3], rr_ptr_d [3];
    logic [2:0]            out_valid_q, out_valid_d;
    logic [3*DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [5:0]            out_src_q, out_src_d;
    logic [CNT_WIDTH-1:0]  drop_count_q, drop_count_d;

    logic [1:0]            head_route [3];
    logic [DATA_WIDTH-1:0] head_data [3];
    logic [2:0]            pop;
    logic [1:0]            sel;

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_src    = out_src_q;
    assign drop_count = drop_count_q;

    function automatic logic [1:0] rr_next(input logic [1:0] ptr, input int unsigned step);
        return 2'((32'(ptr) + step) % 3);
    endfunction

    // Ready depends only on occupancy, so a same-cycle pop never opens a full FIFO.
    always_comb begin
        for (int unsigned i = 0; i < 3; i++) begin
            in_ready[i] = rst_n && (count_q[i] < CNT_W'(FIFO_DEPTH));
        end
    end

    always_comb begin
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        rr_ptr_d     = rr_ptr_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_src_d    = out_src_q;
        drop_count_d = drop_count_q;
        pop          = '0;
        sel          = '0;

        for (int unsigned i = 0; i < 3; i++) begin
            head_route[i] = mem_q[i][rd_ptr_q[i]][ENT_W-1 -: 2];
            head_data[i]  = mem_q[i][rd_ptr_q[i]][DATA_WIDTH-1:0];
        end

        for (int unsigned o = 0; o < 3; o++) begin
            if (!out_valid_q[o] || out_ready[o]) begin
                out_valid_d[o] = 1'b0;
                for (int unsigned k = 1; k <= 3; k++) begin
                    sel = rr_next(rr_ptr_q[o], k);
                    if (!out_valid_d[o] && count_q[sel] != '0 && head_route[sel] == 2'(o)) begin
                        out_valid_d[o]                     = 1'b1;
                        out_data_d[o*DATA_WIDTH +: DATA_WIDTH] = head_data[sel];
                        out_src_d[2*o +: 2]                = sel;
                        rr_ptr_d[o]                        = sel;
                        pop[sel]                           = 1'b1;
                    end
                end
            end
        end

        for (int unsigned i = 0; i < 3; i++) begin
            if (pop[i]) begin
                rd_ptr_d[i] = rd_ptr_q[i] + 1'b1;
                count_d[i]  = count_d[i] - 1'b1;
            end
            if (in_valid[i] && in_ready[i]) begin
                if (in_route[2*i +: 2] == 2'b11) begin
                    if (drop_count_d != '1) begin
                        drop_count_d = drop_count_d + 1'b1;
                    end
                end else begin
                    mem_d[i][wr_ptr_q[i]] = {in_route[2*i +: 2], in_data[i*DATA_WIDTH +: DATA_WIDTH]};
                    wr_ptr_d[i]           = wr_ptr_q[i] + 1'b1;
                    count_d[i]            = count_d[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 3; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                count_q[i]  <= '0;
                rr_ptr_q[i] <= 2'd2;
            end
            out_valid_q  <= '0;
            out_data_q   <= '0;
            out_src_q    <= '0;
            drop_count_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            rr_ptr_q     <= rr_ptr_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_src_q    <= out_src_d;
            drop_count_q <= drop_count_d;
        end
    end
endmodule

// File: tb/tb_ring_port_arbiter.sv
// Scoreboard bench for ring_port_arbiter: expected {src,data} queued per output at push,
// compared when the output handshakes.
module tb_ring_port_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  in_valid;
    logic [2:0]  in_ready;
    logic [95:0] in_data;
    logic [5:0]  in_route;
    logic [2:0]  out_valid;
    logic [2:0]  out_ready;
    logic [95:0] out_data;
    logic [5:0]  out_src;
    logic [7:0]  drop_count;

    int checks   = 0;
    int failures = 0;
    logic [33:0] exp_q [3][$];
    logic [33:0] mon_e;
    logic        ready_ok;

    ring_port_arbiter #(.DATA_WIDTH(32), .FIFO_DEPTH(2), .CNT_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_route(in_route),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_src(out_src),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            for (int o = 0; o < 3; o++) begin
                if (out_valid[o] && out_ready[o]) begin
                    if (exp_q[o].size() != 0) begin
                        mon_e = exp_q[o].pop_front();
                        check($sformatf("out%0d_word", o),
                              {30'b0, out_src[2*o +: 2], out_data[32*o +: 32]}, {30'b0, mon_e});
                    end else begin
                        check($sformatf("out%0d_unexpected", o), 64'(out_valid[o]), 64'd0);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int i, input logic [1:0] r, input logic [31:0] d);
        int waitc = 0;
        in_valid[i]          = 1'b1;
        in_route[2*i +: 2]   = r;
        in_data[32*i +: 32]  = d;
        while (!in_ready[i] && waitc < 50) begin
            tick();
            waitc++;
        end
        if (!in_ready[i]) check("push_timeout", 64'(in_ready[i]), 64'd1);
        @(posedge clk);
        if (r != 2'b11) exp_q[r].push_back({2'(i), d});
        #1;
        in_valid[i] = 1'b0;
    endtask

    task automatic drain();
        int c = 0;
        while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && c < 100) begin
            tick();
            c++;
        end
        check("drain", 64'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size()), 64'd0);
    endtask

    task automatic burst3(input logic [31:0] base);
        check("burst_ready", 64'(in_ready), 64'h7);
        in_valid = 3'b111;
        in_route = 6'b01_01_01;
        in_data  = {base + 32'd2, base + 32'd1, base};
        @(posedge clk);
        for (int i = 0; i < 3; i++) exp_q[1].push_back({2'(i), base + 32'(i)});
        #1;
        in_valid = 3'b000;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("rr_valid%0d", k), 64'(out_valid[1]), 64'd1);
            check($sformatf("rr_src%0d", k), 64'(out_src[3:2]), 64'(k));
        end
        tick();
        check("rr_idle", 64'(out_valid[1]), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 3'b111;
        in_data   = '0;
        in_route  = '0;
        out_ready = 3'b000;

        // 1: reset behaviour
        tick();
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_drop", 64'(drop_count), 64'd0);
        check("rst_out_src", 64'(out_src), 64'd0);
        check("rst_out_data", 64'(out_data[63:0]), 64'd0);
        tick();
        in_valid = 3'b000;
        rst_n    = 1'b1;
        #1;
        check("rel_in_ready", 64'(in_ready), 64'h7);

        // 2: single local word, held while stalled
        push(2, 2'b10, 32'h6000_0001);
        check("lat_early", 64'(out_valid[2]), 64'd0);
        tick();
        check("lat_valid", 64'(out_valid), 64'h4);
        check("lat_data", 64'(out_data[95:64]), 64'h6000_0001);
        check("lat_src", 64'(out_src[5:4]), 64'd2);
        for (int c = 0; c < 5; c++) begin
            tick();
            check("hold_valid", 64'(out_valid[2]), 64'd1);
            check("hold_data", 64'(out_data[95:64]), 64'h6000_0001);
        end
        out_ready[2] = 1'b1;
        tick();
        check("pop_done", 64'(out_valid[2]), 64'd0);

        // 3: round robin on CCW output
        out_ready = 3'b111;
        burst3(32'h1000_0000);
        burst3(32'h2000_0000);
        drain();

        // 4: backpressure and FIFO fill on in1 -> CW
        out_ready = 3'b110;
        push(1, 2'b00, 32'hA0A0_0001);
        push(1, 2'b00, 32'hB0B0_0002);
        push(1, 2'b00, 32'hC0C0_0003);
        check("full_ready", 64'(in_ready[1]), 64'd0);
        check("full_head", 64'(out_data[31:0]), 64'hA0A0_0001);
        out_ready[0] = 1'b1;
        tick();
        check("full_release", 64'(in_ready[1]), 64'd1);
        check("stream_b", 64'(out_data[31:0]), 64'hB0B0_0002);
        tick();
        check("stream_c", 64'(out_data[31:0]), 64'hC0C0_0003);
        tick();
        check("stream_end", 64'(out_valid[0]), 64'd0);
        drain();

        // 5: illegal route drops, saturating counter
        ready_ok      = 1'b1;
        in_valid[0]   = 1'b1;
        in_route[1:0] = 2'b11;
        for (int c = 0; c < 300; c++) begin
            ready_ok = ready_ok & in_ready[0];
            tick();
            if (c == 9) check("drop_10", 64'(drop_count), 64'd10);
        end
        in_valid[0] = 1'b0;
        check("drop_ready", 64'(ready_ok), 64'd1);
        check("drop_sat", 64'(drop_count), 64'd255);
        check("drop_no_out", 64'(out_valid), 64'd0);

        // 6: fill everything, then reset mid-operation
        out_ready = 3'b000;
        for (int i = 0; i < 3; i++)
            for (int w = 0; w < 3; w++)
                push(i, 2'(i), 32'hF000_0000 + 32'(i * 16 + w));
        check("fill_ready", 64'(in_ready), 64'd0);
        check("fill_valid", 64'(out_valid), 64'h7);
        rst_n = 1'b0;
        tick();
        for (int o = 0; o < 3; o++) exp_q[o].delete();
        rst_n = 1'b1;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_ready", 64'(in_ready), 64'h7);
        check("mid_rst_drop", 64'(drop_count), 64'd0);
        out_ready = 3'b111;
        for (int c = 0; c < 10; c++) tick();
        check("stale_valid", 64'(out_valid), 64'd0);
        push(2, 2'b10, 32'h7777_0001);
        push(0, 2'b01, 32'h7777_0002);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
